// File: rtl/mc_path_streamer_if.sv
`default_nettype none
// ============================================================================
// Interface : mc_path_streamer_if
// Brief     : Host load, run control and pricing-core signals of the path
//             streamer; resend_cnt exists only when RESEND_COUNT_EN is defined.
// Revision  : 1.0
// ============================================================================
interface mc_path_streamer_if #(
  parameter int N   = 256,
  parameter int DAY = 8,
  parameter int W   = 12
);
  localparam int c_aw = $clog2(N * DAY);

  logic            ld_valid;
  logic [c_aw-1:0] ld_addr;
  logic [W-1:0]    ld_data;
  logic            go;
  logic            busy;
  logic            core_start;
  logic [W-1:0]    core_path;
  logic            core_resend;
  logic            core_valid;
  logic [W-1:0]    core_price;
  logic [W-1:0]    result;
  logic            result_valid;
  logic            proto_err;
`ifdef RESEND_COUNT_EN
  logic [$clog2(2 * DAY):0] resend_cnt;
`endif

  modport slave (
    input  ld_valid, ld_addr, ld_data, go, core_resend, core_valid, core_price,
    output busy, core_start, core_path, result, result_valid, proto_err
`ifdef RESEND_COUNT_EN
    , output resend_cnt
`endif
  );

  modport master (
    output ld_valid, ld_addr, ld_data, go, core_resend, core_valid, core_price,
    input  busy, core_start, core_path, result, result_valid, proto_err
`ifdef RESEND_COUNT_EN
    , input resend_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mc_path_streamer.sv
`default_nettype none
// ============================================================================
// Module   : mc_path_streamer
// Brief    : Streams stored Monte-Carlo paths to the pricing core in backward-
//            induction order. RESEND_COUNT_EN adds the resend counter/check.
// Revision : 1.0
// ============================================================================
module mc_path_streamer #(
  parameter int N   = 256,
  parameter int DAY = 8,
  parameter int W   = 12
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mc_path_streamer_if.slave bus
);
  localparam int c_iw = $clog2(N);
  localparam int c_dw = $clog2(DAY);
  localparam int c_aw = $clog2(N * DAY);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_dw-1:0] r_day, w_day_nxt, w_rd_day;
  logic [c_iw-1:0] r_idx, w_idx_nxt, w_rd_idx, w_idx_inc;
  logic            r_phase, w_phase_nxt;
  logic            r_start, w_start_nxt;
  logic            r_busy, w_busy_nxt;
  logic [W-1:0]    r_path;
  logic [W-1:0]    r_result;
  logic            r_result_valid, w_result_ld;
  logic            r_err, w_err_set;
  logic            w_path_ld;
  logic [W-1:0]    r_mem [N*DAY];

`ifdef RESEND_COUNT_EN
  localparam int c_cw = $clog2(2 * DAY) + 1;
  logic [c_cw-1:0] r_cnt;
  logic            w_cnt_clr, w_cnt_inc;
`endif

  // r_idx addresses the value loaded at the next edge; it parks on N-1.
  assign w_idx_inc = (r_idx == c_iw'(N - 1)) ? r_idx : r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (bus.ld_valid && (r_state == S_IDLE)) begin
      r_mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_day_nxt   = r_day;
    w_idx_nxt   = r_idx;
    w_phase_nxt = r_phase;
    w_start_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_path_ld   = 1'b0;
    w_rd_day    = r_day;
    w_rd_idx    = r_idx;
    w_result_ld = 1'b0;
    w_err_set   = bus.ld_valid && (r_state != S_IDLE);
`ifdef RESEND_COUNT_EN
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.go) begin
          w_state_nxt = S_STREAM;
          w_start_nxt = 1'b1;
          w_day_nxt   = c_dw'(DAY - 1);
          w_idx_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
`ifdef RESEND_COUNT_EN
          w_cnt_clr   = 1'b1;
`endif
        end
      end
      S_STREAM, S_WAIT: begin
        w_path_ld = 1'b1;
        w_idx_nxt = w_idx_inc;
        if (bus.core_valid) begin
          w_result_ld = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
          if (bus.core_resend) w_err_set = 1'b1;
`ifdef RESEND_COUNT_EN
          if (r_cnt != c_cw'(2 * DAY - 1)) w_err_set = 1'b1;
`endif
        end else if (bus.core_resend) begin
          // WAIT means day 0 has already been replayed: no resend is legal.
          if ((r_state == S_WAIT) || (r_phase && (r_day == '0))) begin
            w_err_set = 1'b1;
          end else begin
            w_rd_idx    = '0;
            w_idx_nxt   = c_iw'(1);
            w_phase_nxt = ~r_phase;
            if (r_phase) begin
              w_day_nxt = r_day - 1'b1;
              w_rd_day  = r_day - 1'b1;
            end else if (r_day == '0) begin
              w_state_nxt = S_WAIT;
            end
`ifdef RESEND_COUNT_EN
            w_cnt_inc = 1'b1;
`endif
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_day          <= '0;
      r_idx          <= '0;
      r_phase        <= 1'b0;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_path         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_day          <= w_day_nxt;
      r_idx          <= w_idx_nxt;
      r_phase        <= w_phase_nxt;
      r_start        <= w_start_nxt;
      r_busy         <= w_busy_nxt;
      r_result_valid <= w_result_ld;
      if (w_path_ld)   r_path   <= r_mem[c_aw'({w_rd_day, w_rd_idx})];
      if (w_result_ld) r_result <= bus.core_price;
      if (w_err_set)   r_err    <= 1'b1;
    end
  end

`ifdef RESEND_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.resend_cnt = r_cnt;
`endif

  assign bus.busy         = r_busy;
  assign bus.core_start   = r_start;
  assign bus.core_path    = r_path;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.proto_err    = r_err;
endmodule
`default_nettype wire

// File: tb/tb_mc_path_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_path_streamer
// Brief    : Self-checking bench; expected path values come from a stored copy
//            of the loaded data and the backward-induction segment order.
// Revision : 1.0
// ============================================================================
module tb_mc_path_streamer;
  localparam int N   = 256;
  localparam int DAY = 8;
  localparam int W   = 12;
  localparam int AW  = $clog2(N * DAY);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [W-1:0] model_mem [N*DAY];
  int           exp_seg;
  int           exp_day;
  int           exp_off;

  mc_path_streamer_if #(.N(N), .DAY(DAY), .W(W)) bus ();

  mc_path_streamer #(.N(N), .DAY(DAY), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    step();
    exp_off++;
  endtask

  // Segment k of a run streams day DAY-1-k/2; every resend opens a new segment.
  task automatic resend_tick();
    bus.core_resend = 1'b1;
    step();
    bus.core_resend = 1'b0;
    exp_seg++;
    exp_day = DAY - 1 - exp_seg / 2;
    exp_off = 0;
  endtask

  task automatic start_run();
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    exp_seg = 0;
    exp_day = DAY - 1;
    exp_off = -1;
  endtask

  task automatic finish_run(input logic [W-1:0] price);
    bus.core_valid = 1'b1;
    bus.core_price = price;
    step();
    bus.core_valid = 1'b0;
  endtask

  task automatic load_mem(input bit incrementing);
    logic [W-1:0] v;
    for (int a = 0; a < N * DAY; a++) begin
      v = incrementing ? W'((a / N) * 16 + (a % N)) : W'($urandom);
      model_mem[a] = v;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = AW'(a);
      bus.ld_data  = v;
      step();
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [W-1:0] exp_path();
    return model_mem[exp_day * N + ((exp_off > N - 1) ? N - 1 : exp_off)];
  endfunction

  task automatic test_reset();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.core_start !== 1'b0) begin n_bad++; $display("FAIL reset_core_start: got %b want 0", bus.core_start); end
    n_cmp++; if (bus.core_path !== '0) begin n_bad++; $display("FAIL reset_core_path: got %0d want 0", bus.core_path); end
    n_cmp++; if (bus.result !== '0) begin n_bad++; $display("FAIL reset_result: got %0d want 0", bus.result); end
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_result_valid: got %b want 0", bus.result_valid); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL reset_proto_err: got %b want 0", bus.proto_err); end
  endtask

  task automatic test_stream();
    load_mem(1'b1);
    start_run();
    n_cmp++; if (bus.core_start !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL start_pulse: start=%b busy=%b want 1/1", bus.core_start, bus.busy); end
    tick();
    n_cmp++; if (bus.core_start !== 1'b0) begin n_bad++; $display("FAIL start_one_cycle: got %b want 0", bus.core_start); end
    n_cmp++; if (bus.core_path !== W'(112)) begin n_bad++; $display("FAIL first_path: got %0d want 112", bus.core_path); end
    for (int i = 1; i < 300; i++) begin
      tick();
      n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL stream_day7: off %0d got %0d want %0d", exp_off, bus.core_path, exp_path()); end
    end
    n_cmp++; if (bus.core_path !== W'(367)) begin n_bad++; $display("FAIL hold_last: got %0d want 367", bus.core_path); end
  endtask

  task automatic test_resend_sequence();
    int gap;
    resend_tick();
    n_cmp++; if (bus.core_path !== W'(112)) begin n_bad++; $display("FAIL replay_day7: got %0d want 112", bus.core_path); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL replay_stream: off %0d got %0d want %0d", exp_off, bus.core_path, exp_path()); end
    end
    resend_tick();
    n_cmp++; if (bus.core_path !== W'(96)) begin n_bad++; $display("FAIL step_day6: got %0d want 96", bus.core_path); end
    while (exp_seg < 2 * DAY - 1) begin
      gap = $urandom_range(0, 280);
      for (int k = 0; k < gap; k++) begin
        tick();
        n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL seq_stream: seg %0d off %0d got %0d want %0d", exp_seg, exp_off, bus.core_path, exp_path()); end
      end
      resend_tick();
      n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL seq_resend: seg %0d got %0d want %0d", exp_seg, bus.core_path, exp_path()); end
    end
    gap = $urandom_range(1, 300);
    for (int k = 0; k < gap; k++) begin
      tick();
      n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL wait_stream: off %0d got %0d want %0d", exp_off, bus.core_path, exp_path()); end
    end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_wait: got %b want 1", bus.busy); end
    finish_run(W'(12'h2A5));
    n_cmp++; if (bus.result !== W'(12'h2A5)) begin n_bad++; $display("FAIL result_value: got %h want 2a5", bus.result); end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL result_valid_high: got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_done: got %b want 0", bus.busy); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL clean_run_err: got %b want 0", bus.proto_err); end
`ifdef RESEND_COUNT_EN
    n_cmp++; if (bus.resend_cnt !== 5'd15) begin n_bad++; $display("FAIL resend_cnt: got %0d want 15", bus.resend_cnt); end
`endif
    step();
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("FAIL result_valid_pulse: got %b want 0", bus.result_valid); end
  endtask

  task automatic test_collision();
    logic [W-1:0] price;
    int           gap;
    start_run();
    tick();
    gap = $urandom_range(5, 50);
    for (int k = 0; k < gap; k++) tick();
    resend_tick();
    n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL coll_pre_resend: got %0d want %0d", bus.core_path, exp_path()); end
    price = W'($urandom);
    bus.core_resend = 1'b1;
    bus.core_valid  = 1'b1;
    bus.core_price  = price;
    step();
    bus.core_resend = 1'b0;
    bus.core_valid  = 1'b0;
    n_cmp++; if (bus.result !== price) begin n_bad++; $display("FAIL coll_result: got %h want %h", bus.result, price); end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL coll_result_valid: got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL coll_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL coll_proto_err: got %b want 1", bus.proto_err); end
  endtask

  task automatic test_load_during_run();
    int addr;
    apply_reset();
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", bus.proto_err); end
    start_run();
    tick();
    addr = (DAY - 1) * N + $urandom_range(0, N - 1);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = AW'(addr);
    bus.ld_data  = ~model_mem[addr];
    tick();
    bus.ld_valid = 1'b0;
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL busy_load_err: got %b want 1", bus.proto_err); end
    n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL busy_load_stream: got %0d want %0d", bus.core_path, exp_path()); end
    finish_run(W'($urandom));
    start_run();
    for (int k = 0; k < N + 4; k++) begin
      tick();
      n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL rerun_stream: off %0d got %0d want %0d", exp_off, bus.core_path, exp_path()); end
    end
    finish_run(W'($urandom));
  endtask

  task automatic test_midrun_reset();
    int gap;
    start_run();
    gap = $urandom_range(20, 200);
    for (int k = 0; k < gap; k++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.core_path !== '0) begin n_bad++; $display("FAIL mid_rst_path: got %0d want 0", bus.core_path); end
    n_cmp++; if (bus.result !== '0) begin n_bad++; $display("FAIL mid_rst_result: got %0d want 0", bus.result); end
    n_cmp++; if (bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %b want 0", bus.proto_err); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.core_start !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle: busy=%b start=%b want 0/0", bus.busy, bus.core_start); end
    start_run();
    n_cmp++; if (bus.core_start !== 1'b1) begin n_bad++; $display("FAIL restart_pulse: got %b want 1", bus.core_start); end
    for (int k = 0; k < N + 4; k++) begin
      tick();
      n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL restart_stream: off %0d got %0d want %0d", exp_off, bus.core_path, exp_path()); end
    end
    finish_run(W'($urandom));
  endtask

  task automatic test_extra_resend();
    apply_reset();
    start_run();
    tick();
    for (int k = 0; k < 2 * DAY - 1; k++) resend_tick();
    n_cmp++; if (bus.core_path !== exp_path() || bus.proto_err !== 1'b0) begin n_bad++; $display("FAIL b2b_last_seg: path %0d err %b want %0d/0", bus.core_path, bus.proto_err, exp_path()); end
    bus.core_resend = 1'b1;
    step();
    bus.core_resend = 1'b0;
    n_cmp++; if (bus.proto_err !== 1'b1) begin n_bad++; $display("FAIL extra_resend_err: got %b want 1", bus.proto_err); end
`ifdef RESEND_COUNT_EN
    n_cmp++; if (bus.resend_cnt !== 5'd15) begin n_bad++; $display("FAIL extra_resend_cnt: got %0d want 15", bus.resend_cnt); end
`endif
    finish_run(W'(12'h123));
    n_cmp++; if (bus.result !== W'(12'h123) || bus.busy !== 1'b0) begin n_bad++; $display("FAIL extra_done: result %h busy %b want 123/0", bus.result, bus.busy); end
  endtask

  task automatic test_random_runs();
    logic [W-1:0] price;
    int           gap;
    for (int r = 0; r < 2; r++) begin
      apply_reset();
      load_mem(1'b0);
      start_run();
      tick();
      n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL rnd_first: run %0d got %0d want %0d", r, bus.core_path, exp_path()); end
      while (exp_seg < 2 * DAY - 1) begin
        gap = $urandom_range(0, (r == 0) ? 3 : 280);
        for (int k = 0; k < gap; k++) begin
          tick();
          n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL rnd_stream: run %0d seg %0d off %0d got %0d want %0d", r, exp_seg, exp_off, bus.core_path, exp_path()); end
        end
        resend_tick();
        n_cmp++; if (bus.core_path !== exp_path()) begin n_bad++; $display("FAIL rnd_resend: run %0d seg %0d got %0d want %0d", r, exp_seg, bus.core_path, exp_path()); end
      end
      gap = $urandom_range(0, 20);
      for (int k = 0; k < gap; k++) tick();
      price = W'($urandom);
      finish_run(price);
      n_cmp++; if (bus.result !== price || bus.result_valid !== 1'b1) begin n_bad++; $display("FAIL rnd_result: run %0d got %h/%b want %h/1", r, bus.result, bus.result_valid, price); end
      n_cmp++; if (bus.proto_err !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rnd_end_state: run %0d err %b busy %b want 0/0", r, bus.proto_err, bus.busy); end
    end
  endtask

  initial begin
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.go          = 1'b0;
    bus.core_resend = 1'b0;
    bus.core_valid  = 1'b0;
    bus.core_price  = '0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_stream();
    test_resend_sequence();
    test_collision();
    test_load_during_run();
    test_midrun_reset();
    test_extra_resend();
    test_random_runs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
